// File: rtl/forward_ctrl.sv
// Forwarding-select and load-use stall control for a 5-stage MIPS pipeline.
// Keeps private copies of the ID/EX, EX/MEM and MEM/WB fields it needs.

module fwd_sel #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_we,
  output logic [1:0]       sel
);
  // EX/MEM is the younger producer, so it is checked first; $0 never forwards.
  always_comb begin
    sel = 2'b00;
    if (src != '0) begin
      if (mem_we && (mem_rd == src))    sel = 2'b10;
      else if (wb_we && (wb_rd == src)) sel = 2'b01;
    end
  end
endmodule

module forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic             flush_i,
  output logic [1:0]       forward_a_o,
  output logic [1:0]       forward_b_o,
  output logic             load_use_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0][REG_W-1:0] ex_src;  // [0] rs, [1] rt
  logic [REG_W-1:0]      mem_rd, wb_rd;
  logic                  mem_we, wb_we;
  logic [CNT_W-1:0]      stall_cnt;
  logic [1:0][1:0]       fwd;
  logic                  load_use;

  assign load_use = ~flush_i & ex_memread_i & (ex_rd_i != '0) &
                    ((ex_rd_i == id_rs_i) | (ex_rd_i == id_rt_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_src    <= '0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      // Flushed or stalled ID instructions enter EX as a bubble.
      if (flush_i || load_use) ex_src <= '0;
      else                     ex_src <= {id_rt_i, id_rs_i};
      mem_rd <= ex_rd_i;
      mem_we <= ex_regwrite_i & ~flush_i;
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      if (load_use && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_sel
    fwd_sel #(.REG_W(REG_W)) u_sel (
      .src    (ex_src[g]),
      .mem_rd (mem_rd),
      .mem_we (mem_we),
      .wb_rd  (wb_rd),
      .wb_we  (wb_we),
      .sel    (fwd[g])
    );
  end

  assign forward_a_o = fwd[0];
  assign forward_b_o = fwd[1];
  assign load_use_o  = load_use;
  assign stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: directed hazard scenarios plus random traffic,
// all checked against an instruction-history reference model.

module tb_forward_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       ex_we, ex_mr, flush;
  logic [1:0] fwd_a, fwd_b;
  logic       lu;
  logic [15:0] cnt;

  forward_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_rd_i(ex_rd), .ex_regwrite_i(ex_we), .ex_memread_i(ex_mr),
    .flush_i(flush), .forward_a_o(fwd_a), .forward_b_o(fwd_b),
    .load_use_o(lu), .stall_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  // Reference: sources of the instruction in EX, plus the two most recent
  // producers leaving EX (age 0 = now in MEM, age 1 = now in WB).
  int m_rs, m_rt, m_cnt;
  int h_rd[2];
  bit h_we[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_fwd(input int src);
    if (src == 0) return 0;
    for (int age = 0; age < 2; age++)
      if (h_we[age] && h_rd[age] == src) return (age == 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit exp_lu();
    return !flush && ex_mr && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
  endfunction

  task automatic set(input int rs, input int rt, input int rd,
                     input bit we, input bit mr, input bit fl);
    id_rs = rs[4:0]; id_rt = rt[4:0]; ex_rd = rd[4:0];
    ex_we = we; ex_mr = mr; flush = fl;
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0);
  endtask

  // Check mid-cycle, then advance the model on the edge with the same inputs.
  task automatic tick();
    bit l;
    @(negedge clk);
    l = exp_lu();
    if (chk_en) begin
      chk("fwd_a", fwd_a, exp_fwd(m_rs));
      chk("fwd_b", fwd_b, exp_fwd(m_rt));
      chk("load_use", lu, l);
      chk("stall_cnt", cnt, m_cnt);
    end
    @(posedge clk);
    if (rst) begin
      m_rs = 0; m_rt = 0; m_cnt = 0;
      h_rd = '{0, 0}; h_we = '{0, 0};
    end else begin
      h_rd[1] = h_rd[0]; h_we[1] = h_we[0];
      h_rd[0] = ex_rd;   h_we[0] = ex_we && !flush;
      if (flush || l) begin m_rs = 0; m_rt = 0; end
      else begin m_rs = id_rs; m_rt = id_rt; end
      if (l && m_cnt < 65535) m_cnt++;
    end
    chk_en = 1;
    #1;
  endtask

  initial begin
    int c0;
    m_rs = 0; m_rt = 0; m_cnt = 0;
    h_rd = '{0, 0}; h_we = '{0, 0};

    // Reset with random inputs
    rst = 1;
    set($urandom_range(31), $urandom_range(31), $urandom_range(31),
        1'($urandom), 1'($urandom), 1'($urandom));
    chk_en = 0;
    @(negedge clk); @(posedge clk); #1;
    m_rs = 0; m_rt = 0;
    tick();
    rst = 0;
    idle(); #1;
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_lu", lu, 0);
    chk("rst_cnt", cnt, 0);
    tick(); tick();

    // EX/MEM forward, src A then src B
    set(8, 0, 8, 1, 0, 0); tick(); idle(); #1;
    chk("exmem_a", fwd_a, 2);
    tick(); tick(); tick();
    set(0, 8, 8, 1, 0, 0); tick(); idle(); #1;
    chk("exmem_b", fwd_b, 2);
    tick(); tick(); tick();

    // MEM/WB forward
    set(0, 0, 9, 1, 0, 0); tick();
    set(9, 0, 3, 1, 0, 0); tick(); idle(); #1;
    chk("memwb_a", fwd_a, 1);
    tick(); tick(); tick();

    // Priority: back-to-back producers of r9
    set(0, 0, 9, 1, 0, 0); tick();
    set(9, 0, 9, 1, 0, 0); tick(); idle(); #1;
    chk("prio_a", fwd_a, 2);
    tick(); tick(); tick();

    // $0 and no-write producers never forward
    set(0, 0, 0, 1, 0, 0); tick(); idle(); #1;
    chk("zero_reg", fwd_a, 0);
    tick(); tick(); tick();
    set(5, 0, 5, 0, 0, 0); tick(); idle(); #1;
    chk("no_write", fwd_a, 0);
    tick(); tick(); tick();

    // Load-use stall
    c0 = m_cnt;
    set(0, 4, 4, 1, 1, 0); #1;
    chk("lu_assert", lu, 1);
    tick(); idle(); #1;
    chk("lu_bubble", fwd_b, 0);
    chk("lu_cnt", cnt, c0 + 1);
    tick(); tick(); tick();

    // Flush squashes both the stall and the producer
    c0 = m_cnt;
    set(7, 0, 7, 1, 1, 1); #1;
    chk("flush_lu", lu, 0);
    tick();
    set(7, 0, 0, 0, 0, 0); #1;
    chk("flush_a1", fwd_a, 0);
    tick(); idle(); #1;
    chk("flush_a2", fwd_a, 0);
    chk("flush_cnt", cnt, c0);
    tick(); tick(); tick();

    // Random traffic with occasional flush and mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      set($urandom_range(7), $urandom_range(7), $urandom_range(7),
          1'($urandom), ($urandom_range(2) == 0), ($urandom_range(9) == 0));
      tick();
    end
    rst = 0;
    idle(); tick(); tick();

    // Saturation: hold a load-use hazard past the counter limit
    set(0, 4, 4, 1, 1, 0);
    for (int i = 0; i < 65540; i++) tick();
    #1;
    chk("sat_hold", cnt, 16'hFFFF);
    tick(); #1;
    chk("sat_more", cnt, 16'hFFFF);

    // Reset mid-stream clears everything
    set(0, 0, 6, 1, 0, 0); tick();
    set(6, 6, 6, 1, 0, 0); rst = 1; tick();
    rst = 0; idle(); #1;
    chk("midrst_a", fwd_a, 0);
    chk("midrst_b", fwd_b, 0);
    chk("midrst_cnt", cnt, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
